// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// It computes one multiplier bit or one quotient bit per clock, over WIDTH
// clocks. The HI and LO outputs change only when a result is committed,
// or on MTHI/MTLO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    // Shadow accumulator. For a multiply it holds {partial product, remaining multiplier}.
    // For a divide it holds {partial remainder, dividend/quotient bits}.
    logic [2*WIDTH-1:0] acc;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]   opd;
    // For a multiply: negate the product. For a divide: negate the quotient.
    logic               neg_q;
    // Negate the remainder; a divide only.
    logic               neg_r;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               last;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;

    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state != S_IDLE);

    // Operand magnitudes and the next step of the shift-add and restoring-divide datapaths
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
        last      = (cnt == CW'(WIDTH - 1));

        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        prod_fix  = neg_q ? -mul_next : mul_next;

        // The difference fits in WIDTH bits whenever the subtraction is kept (div_ge).
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opd});
        div_diff  = div_shift[WIDTH-1:0] - opd;
        div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
        quo_fix   = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        rem_fix   = neg_r ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    end

    // Control state, iteration, and commit of the result to HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opd      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                acc   <= {{WIDTH{1'b0}}, b_mag};
                                opd   <= a_mag;
                                neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r <= 1'b0;
                                cnt   <= '0;
                                state <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (b == '0) begin
                                    done     <= 1'b1;
                                    div_zero <= 1'b1;
                                end else begin
                                    acc   <= {{WIDTH{1'b0}}, a_mag};
                                    opd   <= b_mag;
                                    neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    neg_r <= is_signed & a[WIDTH-1];
                                    cnt   <= '0;
                                    state <= S_DIV;
                                end
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        hi    <= prod_fix[2*WIDTH-1:WIDTH];
                        lo    <= prod_fix[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        hi    <= rem_fix;
                        lo    <= quo_fix;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. It applies a table of vectors and then
// several hand-written sequences. Each expected result goes into a scoreboard
// queue when its operation is issued. It is taken out and compared when done pulses.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Drives a start request at a negedge. Returns at the negedge just after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
    endtask

    // Counts negedges until done is seen, with a fixed bound on the wait.
    task automatic wait_done(output int lat, output int bcnt, output bit ok);
        lat = 0; bcnt = 0; ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcnt++;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name);
        exp_t e;
        chk({name, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({name, "_hi"}, 64'(hi), 64'(e.hi));
            chk({name, "_lo"}, 64'(lo), 64'(e.lo));
            chk({name, "_dz"}, 64'(div_zero), 64'(e.dz));
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        int   lat;
        int   bc;
        bit   ok;
        int   exp_lat;
        e.hi = v.hi; e.lo = v.lo; e.dz = v.dz;
        sb.push_back(e);
        issue(v.op, v.a, v.b);
        wait_done(lat, bc, ok);
        chk({name, "_done_seen"}, 64'(ok), 64'd1);
        check_result(name);
        exp_lat = v.dz ? 0 : W;
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  lat;
        int  bc;
        bit  ok;
        int  pulses;
        exp_t e;
        vec_t v;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[3]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[4]  = '{3'd0, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0};
        vecs[5]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[8]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};
        vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{3'd1, 32'h12345678, 32'h00010000, 32'h00001234, 32'h56780000, 1'b0};

        rst = 1'b1; start = 1'b0; op = 3'd6; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dz", 64'(div_zero), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // MTHI/MTLO preload, then divide by zero leaves HI/LO unchanged
        issue(3'd4, 32'h00001234, 32'h0);
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);
        issue(3'd5, 32'h00005678, 32'h0);
        chk("mtlo_lo", 64'(lo), 64'h5678);
        chk("mtlo_hi_kept", 64'(hi), 64'h1234);
        chk("mtlo_done", 64'(done), 64'd0);
        v = '{3'd3, 32'h00000005, 32'h00000000, 32'h00001234, 32'h00005678, 1'b1};
        run_vec("divzero", v);

        // A start raised while busy is ignored
        e.hi = 32'h0; e.lo = 32'd15; e.dz = 1'b0;
        sb.push_back(e);
        issue(3'd1, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        wait_done(lat, bc, ok);
        chk("ignore_done_seen", 64'(ok), 64'd1);
        chk("ignore_latency", 64'(lat + 5), 64'(W));
        check_result("ignore");
        @(negedge clk);
        chk("ignore_no_second_done", 64'(done), 64'd0);
        chk("ignore_idle", 64'(busy), 64'd0);

        // A start on the done cycle is accepted (back-to-back operations)
        e.hi = 32'h0; e.lo = 32'd42; e.dz = 1'b0;
        sb.push_back(e);
        issue(3'd1, 32'd6, 32'd7);
        wait_done(lat, bc, ok);
        chk("b2b_first_done_seen", 64'(ok), 64'd1);
        check_result("b2b_first");
        e.hi = 32'd2; e.lo = 32'd14; e.dz = 1'b0;
        sb.push_back(e);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        chk("b2b_accepted_busy", 64'(busy), 64'd1);
        wait_done(lat, bc, ok);
        chk("b2b_second_done_seen", 64'(ok), 64'd1);
        chk("b2b_second_latency", 64'(lat), 64'(W));
        check_result("b2b_second");

        // A reset in the middle of a divide discards the operation
        issue(3'd3, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("midrst_no_done", 64'(pulses), 64'd0);
        v = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        run_vec("after_rst", v);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
